serial_bit_source: RTL and testbench
====================================

// Module: serial_bit_source
// PURPOSE
//   Parallel-to-serial stage feeding the din input of the downstream Moore sequence detector.
//   Accepts a WIDTH-bit word over a valid/ready handshake.
//   Shifts the word out MSB-first, one bit per clk, on a registered serial output.
//   Supports back-to-back words with no idle gap, so detection spans word boundaries.
// PARAMETERS
//   WIDTH      8    bits per parallel word (>=2)
//   IDLE_BIT   1'b0 level driven on dout when no word is being shifted
// PORTS
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   data_in     in   WIDTH  parallel word; sampled on handshake
//   load_valid  in   1      producer has a word on data_in
//   load_ready  out  1      block accepts a word this cycle (combinational from state)
//   dout        out  1      serial bit to detector din (registered)
//   dout_valid  out  1      dout carries a data/parity bit this cycle (registered)
//   busy        out  1      high while state != IDLE
//   done        out  1      one-cycle pulse, coincident with the final bit of a word
// BEHAVIOUR
//   Reset (async): state=IDLE, dout=IDLE_BIT, dout_valid=0, done=0, shift reg=0, bit_cnt=0.
//   Handshake: transfer at a rising edge where load_valid && load_ready.
//   load_ready=1 in IDLE, and in the cycle carrying a word's final bit. Otherwise 0.
//   data_in ignored unless load_ready=1.
//   Latency: word accepted at edge N -> bit WIDTH-1 on dout in cycle N+1.
//     Bit 0 appears in cycle N+WIDTH. dout_valid=1 for all of those cycles.
//   FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the optional macro).
//     IDLE  -> SHIFT  on handshake. Load shift reg and set bit_cnt=WIDTH-1.
//     SHIFT: each edge shifts left and decrements bit_cnt.
//       At bit_cnt==0 (final bit), with a handshake -> reload the word and stay in SHIFT (zero gap).
//       At bit_cnt==0 with no handshake -> IDLE.
//       At bit_cnt==0 with the macro -> PARITY.
//     PARITY: one cycle. Exits exactly like the bit_cnt==0 case of SHIFT.
//   done: high in the cycle dout carries the final bit (bit 0, or parity with the macro).
//   Outputs in IDLE: dout=IDLE_BIT, dout_valid=0.
//   Simultaneous handshake and final bit: the new MSB follows in the very next cycle.
//   Reset mid-word: the word is discarded and outputs go to reset values immediately.
//     No partial word resumes after reset is released.
// CONFIGURATION
//   SERIAL_PARITY_EN defined: an even-parity bit (^word) follows bit 0 as one extra dout_valid cycle.
//     Each word then occupies WIDTH+1 cycles.
//   Not defined: no PARITY state, no parity logic, and each word occupies WIDTH cycles.
// STRUCTURE
//   Package serial_src_pkg holds:
//     the state typedef (ST_IDLE, ST_SHIFT, ST_PARITY);
//     the IDLE_BIT default;
//     the counter-width function clog2(WIDTH).
//   Sub-module ser_bit_counter: loadable down-counter with a zero flag.
//     Instantiated once and drives the final-bit decode.
//   Shift register, FSM and output registers stay in the top module.
// TESTING
//   Reset: assert reset asynchronously mid-cycle.
//     Required: dout=0, dout_valid=0, busy=0, done=0, load_ready=1 with no clock edge.
//   Single word: 8'hA5 accepted at edge N.
//     Required: dout=1,0,1,0,0,1,0,1 over cycles N+1..N+8.
//     Also required: done only at N+8, then IDLE at N+9.
//   Back-to-back: 8'hA5, then 8'h0F held valid.
//     Required: 8'h0F accepted at N+8 and its MSB at N+9, with dout_valid never dropping.
//   Busy stall: load_valid=1 with 8'h3C during bits 6..1 of a word.
//     Required: load_ready=0, the current word is unaffected, and 8'h3C is accepted on the final-bit cycle.
//   Mid-word reset: reset after 3 bits of 8'hFF, release, then send 8'h81.
//     Required: the output is exactly 1,0,0,0,0,0,0,1 with no leftover bits.
//   SERIAL_PARITY_EN build, 8'hA5: parity bit 0 at N+9 with done.
//   SERIAL_PARITY_EN build, 8'h07: parity bit 1 at N+9.

Source files
------------

// File: rtl/serial_src_pkg.sv
// Shared types and constants for the serial bit source.
// The optional parity bit is controlled by the SERIAL_PARITY_EN macro in serial_bit_source.
package serial_src_pkg;

    // Shifter states. ST_PARITY is reached only when SERIAL_PARITY_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Level driven on dout while no word is being shifted.
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Bits needed to count down from value-1 to zero.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Loadable down-counter with a zero flag; tracks the bit position of the word in flight.
module ser_bit_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_value;
        end else if (dec) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/serial_bit_source.sv
// Parallel-to-serial stage: accepts a WIDTH-bit word over valid/ready and shifts it out
// MSB-first on a registered dout, one bit per clock, with zero-gap back-to-back words.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity bit after bit 0.
module serial_bit_source
    import serial_src_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    // Holds the bits still to be sent after the one currently on dout.
    logic [WIDTH-2:0] shift_r;
    logic [WIDTH-2:0] shift_s;
    logic             dout_r;
    logic             dout_s;
    logic             dout_valid_r;
    logic             dout_valid_s;
    logic             done_r;
    logic             done_s;
    logic             load_ready_s;
    logic             handshake_s;
    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic [CNT_W-1:0] cnt_s;
    logic             cnt_zero_s;

`ifdef SERIAL_PARITY_EN
    logic             parity_r;
    logic             parity_s;

    // Even parity of a word: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    ser_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load_s),
        .load_value (CNT_LAST),
        .dec        (cnt_dec_s),
        .count      (cnt_s),
        .zero       (cnt_zero_s)
    );

    // Ready decode: open in IDLE and on the cycle carrying a word's final bit.
    always_comb begin
        load_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:   load_ready_s = 1'b1;
`ifdef SERIAL_PARITY_EN
            ST_PARITY: load_ready_s = 1'b1;
`else
            ST_SHIFT:  load_ready_s = cnt_zero_s;
`endif
            default:   load_ready_s = 1'b0;
        endcase
    end

    assign handshake_s = load_valid & load_ready_s;

    // Next-state and next-output decode. A handshake can only occur on an exit cycle,
    // so it always means "load the new word" regardless of the current state.
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        dout_s       = IDLE_BIT;
        dout_valid_s = 1'b0;
        done_s       = 1'b0;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
`ifdef SERIAL_PARITY_EN
        parity_s     = parity_r;
`endif
        if (handshake_s) begin
            state_s      = ST_SHIFT;
            shift_s      = data_in[WIDTH-2:0];
            dout_s       = data_in[WIDTH-1];
            dout_valid_s = 1'b1;
            cnt_load_s   = 1'b1;
`ifdef SERIAL_PARITY_EN
            parity_s     = even_parity(data_in);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (!cnt_zero_s) begin
                        shift_s      = shift_r << 1'b1;
                        dout_s       = shift_r[WIDTH-2];
                        dout_valid_s = 1'b1;
                        cnt_dec_s    = 1'b1;
`ifdef SERIAL_PARITY_EN
                        done_s       = 1'b0;
`else
                        // Counter at one means the bit being loaded now is bit 0.
                        done_s       = (cnt_s == CNT_ONE);
`endif
                    end else begin
`ifdef SERIAL_PARITY_EN
                        state_s      = ST_PARITY;
                        dout_s       = parity_r;
                        dout_valid_s = 1'b1;
                        done_s       = 1'b1;
`else
                        state_s      = ST_IDLE;
`endif
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shift register and registered serial outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r      <= {(WIDTH-1){1'b0}};
            dout_r       <= IDLE_BIT;
            dout_valid_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            shift_r      <= shift_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            done_r       <= done_s;
        end
    end

`ifdef SERIAL_PARITY_EN
    // Parity of the word in flight, captured when the word is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= parity_s;
        end
    end
`endif

    assign load_ready = load_ready_s;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign done       = done_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_serial_bit_source.sv
// Self-checking bench for serial_bit_source. The reference model is a queue of the
// (bit, done) pairs each accepted word will put on dout, one entry per output cycle.
// Honours SERIAL_PARITY_EN the same way as the design.
module tb_serial_bit_source;

    localparam int WIDTH = 8;
`ifdef SERIAL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             dout;
    logic             dout_valid;
    logic             busy;
    logic             done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  exp_q[$];   // {bit, done} for each upcoming output cycle
    logic        acc_m;      // model: word accepted at the last edge
    logic [31:0] cap;        // serial bits seen while dout_valid
    int          ncap;

    serial_bit_source #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dout"},       32'(dout),       32'd0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    endtask

    task automatic check_outputs();
        logic [1:0] h;
        if (exp_q.size() == 0) begin
            check_reset_state("idle");
        end else begin
            h = exp_q[0];
            chk("dout",       32'(dout),       32'(h[1]));
            chk("dout_valid", 32'(dout_valid), 32'd1);
            chk("done",       32'(done),       32'(h[0]));
            chk("busy",       32'(busy),       32'd1);
            chk("load_ready", 32'(load_ready), 32'(exp_q.size() == 1));
        end
        if (dout_valid === 1'b1) begin
            cap  = {cap[30:0], dout};
            ncap = ncap + 1;
        end
    endtask

    // Model update at a rising edge: retire the current output, append a new word if taken.
    task automatic model_edge(input logic v, input logic [WIDTH-1:0] d);
        acc_m = v && (exp_q.size() <= 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (acc_m) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                exp_q.push_back({d[i], (i == 0) && !PAR});
            end
            if (PAR) exp_q.push_back({^d, 1'b1});
        end
    endtask

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d);
        @(negedge clk);
        load_valid = v;
        data_in    = d;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(v, d);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        int guard = 0;
        acc_m = 1'b0;
        while (!acc_m && guard < 40) begin
            cycle(1'b1, d);
            guard++;
        end
        chk("accept_bound", 32'(acc_m), 32'd1);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            cycle(1'b0, 8'h00);
            guard++;
        end
        cycle(1'b0, 8'h00);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        load_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("rst_async");
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_state("rst_held");
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("rst_release");
    endtask

    function automatic logic [31:0] add_word(input logic [31:0] acc, input logic [7:0] w);
        if (PAR) return {acc[22:0], w, ^w};
        else     return {acc[23:0], w};
    endfunction

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        data_in    = 8'h00;
        cap        = 32'd0;
        ncap       = 0;
        exp_q.delete();

        // Asynchronous reset in the middle of a low clock phase.
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        #2;
        reset = 1'b0;

        // Single word.
        cycle(1'b0, 8'h00);
        cap = 32'd0; ncap = 0;
        send_word(8'hA5);
        drain();
        chk("a5_bits", cap, add_word(32'd0, 8'hA5));
        chk("a5_len",  32'(ncap), 32'(WIDTH + int'(PAR)));

        // Back-to-back words, second held valid until taken.
        cap = 32'd0; ncap = 0;
        send_word(8'hA5);
        send_word(8'h0F);
        drain();
        chk("b2b_bits", cap, add_word(add_word(32'd0, 8'hA5), 8'h0F));
        chk("b2b_len",  32'(ncap), 32'(2 * (WIDTH + int'(PAR))));

        // Stall: next word offered while the current one is still shifting.
        cap = 32'd0; ncap = 0;
        send_word(8'h5A);
        cycle(1'b0, 8'h00);
        send_word(8'h3C);
        drain();
        chk("stall_bits", cap, add_word(add_word(32'd0, 8'h5A), 8'h3C));

        // Reset partway through a word; nothing of it may survive.
        send_word(8'hFF);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        mid_reset();
        cap = 32'd0; ncap = 0;
        send_word(8'h81);
        drain();
        chk("post_rst_bits", cap, add_word(32'd0, 8'h81));
        chk("post_rst_len",  32'(ncap), 32'(WIDTH + int'(PAR)));

        // Parity-relevant words (parity 0 and 1).
        send_word(8'h07);
        drain();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                mid_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, 8'($urandom));
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
